// File: rtl/stretch_pkg.sv
// Shared types and parameter limits for the multi-channel pulse stretcher.
package stretch_pkg;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_GAP} stretch_state_t;

  localparam int MIN_CHANNELS    = 1;
  localparam int MIN_HOLD_CYCLES = 1;
  localparam int MAX_SYNC_STAGES = 3;

  // Width that holds 0..hold without wrapping.
  function automatic int cnt_width(input int hold);
    return $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/pulse_stretch_chan.sv
// One stretcher channel: synchroniser, rising-edge detect, HOLD/GAP FSM with
// one-deep request queue and sticky overflow flag.
module pulse_stretch_chan
  import stretch_pkg::*;
#(
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_TICK   = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_tick,
  input  logic in_req,
  input  logic clr_overflow,
  output logic pulse_out,
  output logic busy,
  output logic overflow
);

  localparam int CNT_W = cnt_width(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  logic synced;
  logic prev_q;
  logic evt;

  stretch_state_t state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic pending_q, pending_d;
  logic tick_seen_q, tick_seen_d;
  logic drop;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = in_req;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= in_req;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end
      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  assign evt = synced & ~prev_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    pending_d   = pending_q;
    tick_seen_d = tick_seen_q;
    drop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (evt) begin
          state_d     = S_HOLD;
          count_d     = HOLD_LOAD;
          tick_seen_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (count_q != '0) count_d = count_q - CNT_W'(1);
        if (sample_tick) tick_seen_d = 1'b1;
        if (evt) begin
          if (pending_q) drop = 1'b1;
          else pending_d = 1'b1;
        end
        // An edge arriving in the exit cycle still queues, so it must lead to GAP.
        if (count_q == '0 && (WAIT_TICK == 0 || tick_seen_q || sample_tick))
          state_d = pending_d ? S_GAP : S_IDLE;
      end
      S_GAP: begin
        state_d     = S_HOLD;
        count_d     = HOLD_LOAD;
        tick_seen_d = 1'b0;
        pending_d   = evt;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= 1'b0;
      state_q     <= S_IDLE;
      count_q     <= '0;
      pending_q   <= 1'b0;
      tick_seen_q <= 1'b0;
      pulse_out   <= 1'b0;
      busy        <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      prev_q      <= synced;
      state_q     <= state_d;
      count_q     <= count_d;
      pending_q   <= pending_d;
      tick_seen_q <= tick_seen_d;
      pulse_out   <= (state_d == S_HOLD);
      busy        <= (state_d != S_IDLE) || pending_d;
      overflow    <= drop | (overflow & ~clr_overflow);
    end
  end

endmodule

// File: rtl/multi_pulse_stretch_sync.sv
// Multi-channel request stretcher: independent channels sharing sample_tick
// and clr_overflow.
module multi_pulse_stretch_sync
  import stretch_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int SYNC_STAGES = 2,
  parameter int WAIT_TICK   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_tick,
  input  logic [CHANNELS-1:0] in_req,
  input  logic                clr_overflow,
  output logic [CHANNELS-1:0] pulse_out,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] overflow
);

  generate
    if (CHANNELS < MIN_CHANNELS || HOLD_CYCLES < MIN_HOLD_CYCLES ||
        SYNC_STAGES < 0 || SYNC_STAGES > MAX_SYNC_STAGES ||
        (WAIT_TICK != 0 && WAIT_TICK != 1)) begin : g_param_err
      $error("multi_pulse_stretch_sync: parameter out of range");
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      pulse_stretch_chan #(
        .HOLD_CYCLES(HOLD_CYCLES),
        .SYNC_STAGES(SYNC_STAGES),
        .WAIT_TICK  (WAIT_TICK)
      ) u_chan (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_tick (sample_tick),
        .in_req      (in_req[g]),
        .clr_overflow(clr_overflow),
        .pulse_out   (pulse_out[g]),
        .busy        (busy[g]),
        .overflow    (overflow[g])
      );
    end
  endgenerate

endmodule
